// File: rtl/sha256_message_schedule.sv
// SHA-256 message schedule: streams W[0..63] of one or two 512-bit blocks,
// one word per handshake, using a 16-word sliding window.
module sha256_message_schedule (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [0:1023] padded_message,
    input  logic [0:1]    num_blocks,
    input  logic          in_valid,
    output logic          in_ready,
    output logic [0:31]   w_word,
    output logic [0:5]    w_index,
    output logic          w_block,
    output logic          w_last_in_block,
    output logic          w_last,
    output logic          w_valid,
    input  logic          w_ready
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t       state;
    logic [31:0]  window [16];
    logic [0:511] hold_block;
    logic         two_blocks;
    logic [5:0]   idx;
    logic         blk;
    logic [31:0]  next_word;

    function automatic logic [31:0] sig0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    function automatic logic [31:0] sig1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

    // W[t+16] from the window as seen while W[t] sits in window[0]
    always_comb begin
        next_word = sig1(window[14]) + window[9] + sig0(window[1]) + window[0];
    end

    assign in_ready        = (state == IDLE);
    assign w_valid         = (state == RUN);
    assign w_word          = window[0];
    assign w_index         = idx;
    assign w_block         = blk;
    assign w_last_in_block = w_valid && (idx == 6'd63);
    assign w_last          = w_last_in_block && (blk || !two_blocks);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            for (int k = 0; k < 16; k++) window[k] <= '0;
            hold_block <= '0;
            two_blocks <= 1'b0;
            idx        <= '0;
            blk        <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        for (int k = 0; k < 16; k++) window[k] <= padded_message[32*k +: 32];
                        hold_block <= padded_message[512:1023];
                        // num_blocks 0 behaves as 1, 3 behaves as 2: only the MSB matters
                        two_blocks <= num_blocks[0];
                        idx        <= '0;
                        blk        <= 1'b0;
                        state      <= RUN;
                    end
                end
                RUN: begin
                    if (w_ready) begin
                        if (idx != 6'd63) begin
                            for (int k = 0; k < 15; k++) window[k] <= window[k+1];
                            window[15] <= next_word;
                            idx        <= idx + 6'd1;
                        end else if (!blk && two_blocks) begin
                            for (int k = 0; k < 16; k++) window[k] <= hold_block[32*k +: 32];
                            idx <= '0;
                            blk <= 1'b1;
                        end else begin
                            idx   <= '0;
                            blk   <= 1'b0;
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
